// File: rtl/dataint_ecc_pkg.sv
// Shared types and constant helpers for the SECDED encoder pipeline.
// Hamming positions are 1-based; codeword index j holds Hamming position j+1.
package dataint_ecc_pkg;

    localparam int MAX_TW = 256;

    typedef enum logic [1:0] {
        INJ_NONE   = 2'd0,
        INJ_SINGLE = 2'd1,
        INJ_DOUBLE = 2'd2,
        INJ_RSVD   = 2'd3
    } inj_mode_e;

    function automatic int secded_pb(input int width);
        return $clog2(width + $clog2(width) + 1);
    endfunction

    function automatic int secded_tw(input int width);
        return width + secded_pb(width) + 1;
    endfunction

    // Codeword indices covered by parity bit pbit (its own slot and the overall bit excluded).
    function automatic logic [MAX_TW-1:0] secded_encode(input int width, input int pbit);
        logic [MAX_TW-1:0] mask;
        mask = '0;
        for (int j = 0; j < secded_tw(width) - 1; j++) begin
            if ((j != (1 << pbit) - 1) && ((((j + 1) >> pbit) & 1) != 0)) begin
                mask = mask | ({{(MAX_TW-1){1'b0}}, 1'b1} << j);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/dataint_ecc_secded_enc_lane.sv
// Combinational single-lane Hamming SECDED encoder.
// Data fills the non-power-of-two positions; the top bit is overall parity.
module dataint_ecc_secded_enc_lane
    import dataint_ecc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]            data_i,
    output logic [secded_tw(WIDTH)-1:0] code_o
);

    localparam int PB = secded_pb(WIDTH);
    localparam int TW = secded_tw(WIDTH);

    logic [TW-2:0] placed_s;
    logic [TW-2:0] body_s;
    logic [PB-1:0] parity_s;

    // Position j+1 is a power of two exactly when (j+1)&j is zero.
    for (genvar j = 0; j < TW - 1; j++) begin : g_place
        if (((j + 1) & j) == 0) begin : g_par
            assign placed_s[j] = 1'b0;
            assign body_s[j]   = parity_s[$clog2(j + 1)];
        end else begin : g_dat
            assign placed_s[j] = data_i[j - $clog2(j + 2)];
            assign body_s[j]   = placed_s[j];
        end
    end

    for (genvar i = 0; i < PB; i++) begin : g_pbit
        localparam logic [MAX_TW-1:0] MASK = secded_encode(WIDTH, i);
        assign parity_s[i] = ^(placed_s & MASK[TW-2:0]);
    end

    assign code_o = {^body_s, body_s};

endmodule

// File: rtl/dataint_ecc_secded_enc_pipe.sv
// Multi-lane SECDED encoder pipeline with valid/ready flow control,
// one-shot test error injection and saturating delivery statistics.
module dataint_ecc_secded_enc_pipe
    import dataint_ecc_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LANES  = 1,
    parameter int REG_IN = 1,
    parameter int CNT_W  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [LANES*WIDTH-1:0]              s_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [LANES*secded_tw(WIDTH)-1:0]   m_code,
    input  logic                                inj_arm,
    input  logic [1:0]                          inj_mode,
    input  logic [$clog2(LANES):0]              inj_lane,
    input  logic [$clog2(secded_tw(WIDTH)):0]   inj_pos0,
    input  logic [$clog2(secded_tw(WIDTH)):0]   inj_pos1,
    output logic                                inj_armed,
    output logic [CNT_W-1:0]                    beat_cnt,
    output logic [CNT_W-1:0]                    inj_cnt
);

    localparam int TW = secded_tw(WIDTH);
    localparam int LW = $clog2(LANES) + 1;
    localparam int PW = $clog2(TW) + 1;
    localparam int CW = LANES * TW;
    localparam int DW = LANES * WIDTH;
    localparam logic [TW-1:0]    ONE_TW  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             rdy_q;
    logic             armed_q, armed_d;
    inj_mode_e        mode_q, mode_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [PW-1:0]    pos0_q, pos0_d, pos1_q, pos1_d;
    logic             out_v_q, out_v_d, tag_q, tag_d;
    logic [CW-1:0]    code_q, code_d;
    logic [CNT_W-1:0] beat_q, beat_d, injc_q, injc_d;

    logic             out_load_s, stage_rdy_s, accept_s, arm_ok_s, bind_s, deliver_s;
    inj_mode_e        eff_mode_s;
    logic [LW-1:0]    eff_lane_s;
    logic [PW-1:0]    eff_pos0_s, eff_pos1_s;
    logic [CW-1:0]    in_mask_s, src_mask_s, enc_s;
    logic [DW-1:0]    src_data_s;
    logic             src_v_s, src_tag_s;

    assign out_load_s = !out_v_q || m_ready;
    assign s_ready    = rdy_q && stage_rdy_s;
    assign accept_s   = s_valid && s_ready;
    assign deliver_s  = out_v_q && m_ready;
    assign arm_ok_s   = inj_arm && !armed_q &&
                        ((inj_mode == INJ_SINGLE) || (inj_mode == INJ_DOUBLE));

    // Injection seen by the beat accepted now: pending shadow first, else a same-cycle arm.
    always_comb begin
        eff_mode_s = INJ_NONE;
        eff_lane_s = '0;
        eff_pos0_s = '0;
        eff_pos1_s = '0;
        if (armed_q) begin
            eff_mode_s = mode_q;
            eff_lane_s = lane_q;
            eff_pos0_s = pos0_q;
            eff_pos1_s = pos1_q;
        end else if (arm_ok_s) begin
            eff_mode_s = inj_mode_e'(inj_mode);
            eff_lane_s = inj_lane;
            eff_pos0_s = inj_pos0;
            eff_pos1_s = inj_pos1;
        end else begin
            eff_mode_s = INJ_NONE;
        end
    end

    assign bind_s = accept_s && (eff_mode_s != INJ_NONE);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [TW-1:0] flip_s;

        // Out-of-range positions shift the single set bit away, so they flip nothing.
        always_comb begin
            flip_s = '0;
            if ((eff_mode_s != INJ_NONE) && (eff_lane_s == LW'(k))) begin
                if (eff_mode_s == INJ_DOUBLE) begin
                    flip_s = (ONE_TW << eff_pos0_s) ^ (ONE_TW << eff_pos1_s);
                end else begin
                    flip_s = ONE_TW << eff_pos0_s;
                end
            end else begin
                flip_s = '0;
            end
        end

        assign in_mask_s[k*TW +: TW] = flip_s;

        dataint_ecc_secded_enc_lane #(.WIDTH(WIDTH)) u_enc (
            .data_i (src_data_s[k*WIDTH +: WIDTH]),
            .code_o (enc_s[k*TW +: TW])
        );
    end

    if (REG_IN != 0) begin : g_in_reg
        logic          s1_v_q, s1_tag_q;
        logic [DW-1:0] s1_data_q;
        logic [CW-1:0] s1_mask_q;

        // Input stage refills whenever it is empty or its beat moves to the output stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_v_q    <= 1'b0;
                s1_tag_q  <= 1'b0;
                s1_data_q <= '0;
                s1_mask_q <= '0;
            end else if (stage_rdy_s) begin
                s1_v_q    <= accept_s;
                s1_tag_q  <= bind_s;
                s1_data_q <= s_data;
                s1_mask_q <= in_mask_s;
            end
        end

        assign stage_rdy_s = !s1_v_q || out_load_s;
        assign src_v_s     = s1_v_q;
        assign src_tag_s   = s1_tag_q;
        assign src_data_s  = s1_data_q;
        assign src_mask_s  = s1_mask_q;
    end else begin : g_in_pass
        assign stage_rdy_s = out_load_s;
        assign src_v_s     = accept_s;
        assign src_tag_s   = bind_s;
        assign src_data_s  = s_data;
        assign src_mask_s  = in_mask_s;
    end

    // Output stage, injection shadow and saturating counters.
    always_comb begin
        out_v_d = out_v_q;
        code_d  = code_q;
        tag_d   = tag_q;
        armed_d = armed_q;
        mode_d  = mode_q;
        lane_d  = lane_q;
        pos0_d  = pos0_q;
        pos1_d  = pos1_q;
        beat_d  = beat_q;
        injc_d  = injc_q;
        if (out_load_s) begin
            out_v_d = src_v_s;
            tag_d   = src_v_s && src_tag_s;
            code_d  = src_v_s ? (enc_s ^ src_mask_s) : code_q;
        end else begin
            out_v_d = out_v_q;
        end
        if (bind_s) begin
            armed_d = 1'b0;
        end else if (arm_ok_s) begin
            armed_d = 1'b1;
            mode_d  = inj_mode_e'(inj_mode);
            lane_d  = inj_lane;
            pos0_d  = inj_pos0;
            pos1_d  = inj_pos1;
        end else begin
            armed_d = armed_q;
        end
        if (deliver_s && (beat_q != CNT_MAX)) begin
            beat_d = beat_q + CNT_ONE;
        end else begin
            beat_d = beat_q;
        end
        if (deliver_s && tag_q && (injc_q != CNT_MAX)) begin
            injc_d = injc_q + CNT_ONE;
        end else begin
            injc_d = injc_q;
        end
    end

    // State registers; s_ready stays low until the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q   <= 1'b0;
            out_v_q <= 1'b0;
            code_q  <= '0;
            tag_q   <= 1'b0;
            armed_q <= 1'b0;
            mode_q  <= INJ_NONE;
            lane_q  <= '0;
            pos0_q  <= '0;
            pos1_q  <= '0;
            beat_q  <= '0;
            injc_q  <= '0;
        end else begin
            rdy_q   <= 1'b1;
            out_v_q <= out_v_d;
            code_q  <= code_d;
            tag_q   <= tag_d;
            armed_q <= armed_d;
            mode_q  <= mode_d;
            lane_q  <= lane_d;
            pos0_q  <= pos0_d;
            pos1_q  <= pos1_d;
            beat_q  <= beat_d;
            injc_q  <= injc_d;
        end
    end

    assign m_valid   = out_v_q;
    assign m_code    = code_q;
    assign inj_armed = armed_q;
    assign beat_cnt  = beat_q;
    assign inj_cnt   = injc_q;

endmodule
